// File: rtl/fd_scan_sched.sv
// Raster scan scheduler for the FAST corner detector: fetches each interior pixel's
// 16-point circle, hands it to the datapath, and emits corners. Optional macro: FD_CORNER_COUNT_EN.
module fd_scan_sched #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 128,
    parameter int BORDER = 3
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [14:0] refAddr,
    output logic [4:0]  adjNumber,
    output logic [4:0]  regAddr,
    output logic        readen,
    input  logic        isCorner,
    output logic        cornerValid,
    input  logic        cornerReady,
`ifdef FD_CORNER_COUNT_EN
    output logic [14:0] cornerCount,
`endif
    output logic [14:0] cornerAddr
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(BORDER);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1 - BORDER);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(BORDER);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1 - BORDER);
    localparam logic [4:0]       ADJ_LAST  = 5'd16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_EMIT  = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    logic [2:0]       r_state;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [4:0]       r_adj;
    logic [4:0]       r_reg_addr;
    logic             r_readen;
    logic             r_busy;
    logic             r_done;
    logic             r_cvalid;
    logic [14:0]      r_caddr;

    logic [2:0]       w_state;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic [4:0]       w_adj;
    logic [4:0]       w_reg_addr;
    logic             w_readen;
    logic [14:0]      w_caddr;
    logic [ROW_W-1:0] w_nxt_row;
    logic [COL_W-1:0] w_nxt_col;
    logic             w_scan_end;
    logic             w_handshake;
    logic             w_advance;

    assign w_scan_end  = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_handshake = (r_state == ST_EMIT) && cornerReady;

    // Next raster position: step right, wrapping to the first interior column of the next row.
    always_comb begin
        w_nxt_row = r_row;
        w_nxt_col = r_col;
        if (r_col == COL_LAST) begin
            w_nxt_col = COL_FIRST;
            w_nxt_row = r_row + ROW_W'(1);
        end else begin
            w_nxt_col = r_col + COL_W'(1);
        end
    end

    // Scan state machine and next-value computation for every registered output.
    always_comb begin
        w_state    = r_state;
        w_row      = r_row;
        w_col      = r_col;
        w_adj      = r_adj;
        w_reg_addr = r_reg_addr;
        w_readen   = 1'b0;
        w_caddr    = r_caddr;
        w_advance  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state = ST_FETCH;
                    w_row   = ROW_FIRST;
                    w_col   = COL_FIRST;
                    w_adj   = 5'd0;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // SRAM data for index adj arrives one cycle later, so the write index lags by one.
                w_readen   = 1'b1;
                w_reg_addr = r_adj;
                if (r_adj == ADJ_LAST) begin
                    w_state = ST_DRAIN;
                end else begin
                    w_adj = r_adj + 5'd1;
                end
            end
            ST_DRAIN: begin
                w_state = ST_EVAL;
            end
            ST_EVAL: begin
                if (isCorner) begin
                    w_state = ST_EMIT;
                    w_caddr = {r_row, r_col};
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (w_handshake) begin
                    w_advance = 1'b1;
                end else begin
                    w_state = ST_EMIT;
                end
            end
            ST_FIN: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            if (w_scan_end) begin
                w_state = ST_FIN;
            end else begin
                w_state = ST_FETCH;
                w_row   = w_nxt_row;
                w_col   = w_nxt_col;
                w_adj   = 5'd0;
            end
        end else begin
            w_adj = w_adj;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_adj      <= 5'd0;
            r_reg_addr <= 5'd0;
            r_readen   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cvalid   <= 1'b0;
            r_caddr    <= 15'd0;
        end else begin
            r_state    <= w_state;
            r_row      <= w_row;
            r_col      <= w_col;
            r_adj      <= w_adj;
            r_reg_addr <= w_reg_addr;
            r_readen   <= w_readen;
            r_busy     <= (w_state == ST_FETCH) || (w_state == ST_DRAIN) ||
                          (w_state == ST_EVAL)  || (w_state == ST_EMIT);
            r_done     <= (w_state == ST_FIN);
            r_cvalid   <= (w_state == ST_EMIT);
            r_caddr    <= w_caddr;
        end
    end

`ifdef FD_CORNER_COUNT_EN
    logic [14:0] r_count;

    // Corners accepted downstream in the current frame; held after done.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_count <= 15'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_count <= 15'd0;
        end else if (w_handshake) begin
            r_count <= r_count + 15'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign cornerCount = r_count;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign refAddr     = {r_row, r_col};
    assign adjNumber   = r_adj;
    assign regAddr     = r_reg_addr;
    assign readen      = r_readen;
    assign cornerValid = r_cvalid;
    assign cornerAddr  = r_caddr;

endmodule

// File: tb/tb_fd_scan_sched.sv
// Randomized bench for fd_scan_sched: a default-geometry instance for the scan start, row wrap,
// corner stall and reset cases, and a wide-border instance to reach end of frame quickly.
module tb_fd_scan_sched;

    localparam int IMG_W = 256;
    localparam int IMG_H = 128;

    logic clock = 1'b0;
    logic nReset;
    logic start;
    logic sel;
    logic isCorner;
    logic cornerReady;
    logic start_a, start_b;

    logic        busy_a, done_a, readen_a, cvalid_a;
    logic [14:0] ref_a, caddr_a;
    logic [4:0]  adj_a, rega_a;
    logic        busy_b, done_b, readen_b, cvalid_b;
    logic [14:0] ref_b, caddr_b;
    logic [4:0]  adj_b, rega_b;
    logic [14:0] cnt_a, cnt_b;

    logic        o_busy, o_done, o_readen, o_cvalid;
    logic [14:0] o_ref, o_caddr, o_cnt;
    logic [4:0]  o_adj, o_rega;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    fd_scan_sched dut_a (
        .clock(clock), .nReset(nReset), .start(start_a),
        .busy(busy_a), .done(done_a), .refAddr(ref_a), .adjNumber(adj_a),
        .regAddr(rega_a), .readen(readen_a), .isCorner(isCorner),
        .cornerValid(cvalid_a), .cornerReady(cornerReady),
`ifdef FD_CORNER_COUNT_EN
        .cornerCount(cnt_a),
`endif
        .cornerAddr(caddr_a)
    );

    fd_scan_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(62)) dut_b (
        .clock(clock), .nReset(nReset), .start(start_b),
        .busy(busy_b), .done(done_b), .refAddr(ref_b), .adjNumber(adj_b),
        .regAddr(rega_b), .readen(readen_b), .isCorner(isCorner),
        .cornerValid(cvalid_b), .cornerReady(cornerReady),
`ifdef FD_CORNER_COUNT_EN
        .cornerCount(cnt_b),
`endif
        .cornerAddr(caddr_b)
    );

`ifndef FD_CORNER_COUNT_EN
    assign cnt_a = 15'd0;
    assign cnt_b = 15'd0;
`endif

    always_comb begin
        if (sel) begin
            o_busy = busy_b; o_done = done_b; o_readen = readen_b; o_cvalid = cvalid_b;
            o_ref = ref_b; o_caddr = caddr_b; o_adj = adj_b; o_rega = rega_b; o_cnt = cnt_b;
        end else begin
            o_busy = busy_a; o_done = done_a; o_readen = readen_a; o_cvalid = cvalid_a;
            o_ref = ref_a; o_caddr = caddr_a; o_adj = adj_a; o_rega = rega_a; o_cnt = cnt_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"},   32'(o_busy),   32'd0);
        chk({tag, ".done"},   32'(o_done),   32'd0);
        chk({tag, ".readen"}, 32'(o_readen), 32'd0);
        chk({tag, ".cvalid"}, 32'(o_cvalid), 32'd0);
        chk({tag, ".ref"},    32'(o_ref),    32'd0);
        chk({tag, ".adj"},    32'(o_adj),    32'd0);
        chk({tag, ".regaddr"},32'(o_rega),   32'd0);
        chk({tag, ".caddr"},  32'(o_caddr),  32'd0);
`ifdef FD_CORNER_COUNT_EN
        chk({tag, ".count"},  32'(o_cnt),    32'd0);
`endif
    endtask

    // Walk the interior of the frame in raster order; called at the first FETCH cycle.
    task automatic run_scan(input int b, input int rst_at);
        int pix = 0;
        int corners = 0;
        int last_ref = (IMG_H - 1 - b) * IMG_W + (IMG_W - 1 - b);
        for (int r = b; r <= IMG_H - 1 - b; r++) begin
            for (int c = b; c <= IMG_W - 1 - b; c++) begin
                int  ref_exp = r * IMG_W + c;
                bit  corner  = ($urandom_range(0, 7) == 0);
                int  stall   = $urandom_range(0, 3);
                if (ref_exp == 1000) begin
                    corner = 1'b1;
                    stall  = 5;
                end
                if (pix == rst_at) corner = 1'b1;
                for (int k = 0; k <= 18; k++) begin
                    if (k > 0) tick();
                    chk("pix.busy",   32'(o_busy),   32'd1);
                    chk("pix.done",   32'(o_done),   32'd0);
                    chk("pix.ref",    32'(o_ref),    32'(ref_exp));
                    chk("pix.cvalid", 32'(o_cvalid), 32'd0);
                    chk("pix.readen", 32'(o_readen), 32'(k >= 1 && k <= 17));
                    if (k <= 16) chk("pix.adj", 32'(o_adj), 32'(k));
                    if (k >= 1 && k <= 17) chk("pix.regaddr", 32'(o_rega), 32'((k == 17) ? 16 : k - 1));
`ifdef FD_CORNER_COUNT_EN
                    if (pix == 0 && k == 0) chk("count.clear", 32'(o_cnt), 32'd0);
`endif
                    isCorner    = (k == 18) ? corner : 1'($urandom);
                    cornerReady = 1'($urandom);
                    start       = (k >= 2 && k <= 15 && $urandom_range(0, 31) == 0);
                end
                if (corner) begin
                    tick();
                    for (int s = 0; s <= stall; s++) begin
                        chk("emit.cvalid", 32'(o_cvalid), 32'd1);
                        chk("emit.caddr",  32'(o_caddr),  32'(ref_exp));
                        chk("emit.busy",   32'(o_busy),   32'd1);
                        chk("emit.readen", 32'(o_readen), 32'd0);
                        chk("emit.ref",    32'(o_ref),    32'(ref_exp));
                        if (pix == rst_at) begin
                            #2 nReset = 1'b0;
                            #1 check_idle("rst_emit");
                            tick();
                            nReset = 1'b1;
                            repeat (3) tick();
                            check_idle("no_resume");
                            return;
                        end
                        isCorner    = 1'($urandom);
                        cornerReady = (s == stall);
                        tick();
                    end
                    corners++;
                end else begin
                    tick();
                end
                pix++;
            end
        end
        chk("fin.done",   32'(o_done),   32'd1);
        chk("fin.busy",   32'(o_busy),   32'd0);
        chk("fin.readen", 32'(o_readen), 32'd0);
        chk("fin.ref",    32'(o_ref),    32'(last_ref));
`ifdef FD_CORNER_COUNT_EN
        chk("fin.count",  32'(o_cnt),    32'(corners));
`endif
        tick();
        chk("idle.done", 32'(o_done), 32'd0);
        chk("idle.busy", 32'(o_busy), 32'd0);
        repeat (3) tick();
        chk("idle.done2", 32'(o_done), 32'd0);
        chk("idle.busy2", 32'(o_busy), 32'd0);
`ifdef FD_CORNER_COUNT_EN
        chk("hold.count", 32'(o_cnt), 32'(corners));
`endif
    endtask

    initial begin
        nReset = 1'b0; start = 1'b0; sel = 1'b0; isCorner = 1'b0; cornerReady = 1'b0;
        repeat (2) tick();
        check_idle("resetA");
        sel = 1'b1; #1 check_idle("resetB");
        sel = 1'b0;
        nReset = 1'b1;
        isCorner = 1'b1; cornerReady = 1'b1;
        repeat (2) tick();
        check_idle("idleA");

        start = 1'b1;
        tick();
        run_scan(3, 255);

        sel = 1'b1; start = 1'b0;
        tick();
        check_idle("idleB");
        start = 1'b1;
        tick();
        run_scan(62, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
